// File: rtl/ibuff_pkg.sv
// Shared types and constants for the instruction-buffer sequencing controller.
// No logic here: state encoding, buffer geometry and default line offset width.
// Imported by ibuff_ctrl.
package ibuff_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Buffer geometry: four slots, slot index is line address modulo 4
    localparam int NUM_ENTRIES = 4;
    localparam int IDX_W       = 2;

    // Line offset width for the default 16-byte cache line
    localparam int LINE_OFF_W  = 4;

endpackage

// File: rtl/ibuff_ctrl.sv
// Instruction-buffer sequencer: issues line fetches, allocates/loads/frees the 4 slots, flushes on redirect.
// Latency: request one cycle after FLUSH; load strobe combinational with the response; head visible the cycle after load.
// Backpressure: request valid/addr hold while fetch_req_ready=0; no new request while 4 slots allocated or MAX_INFLIGHT outstanding.
module ibuff_ctrl
    import ibuff_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_BYTES   = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fetch_req_valid,
    input  logic                  fetch_req_ready,
    output logic [ADDR_WIDTH-1:0] fetch_req_addr,
    input  logic                  fetch_resp_valid,
    input  logic [3:0]            ibuf_valid,
    output logic [3:0]            ibuf_load,
    output logic [3:0]            ibuf_invalidate,
    input  logic                  deq_ready,
    output logic                  head_valid,
    output logic [1:0]            head_idx,
    output logic [ADDR_WIDTH-1:0] head_pc
);

    localparam int                    OFF_W    = $clog2(LINE_BYTES);
    localparam logic [2:0]            CNT_MAX  = 3'(NUM_ENTRIES);
    localparam logic [2:0]            INF_MAX  = 3'(MAX_INFLIGHT);
    localparam logic [ADDR_WIDTH-1:0] LINE_INC = ADDR_WIDTH'(LINE_BYTES);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   next_line_q, next_line_d;
    logic [ADDR_WIDTH-1:0]   head_pc_q, head_pc_d;
    logic [IDX_W-1:0]        head_q, head_d;
    logic [IDX_W-1:0]        tail_q, tail_d;
    logic [IDX_W-1:0]        fill_q, fill_d;
    logic [2:0]              count_q, count_d;
    logic [2:0]              inflight_q, inflight_d;
    // Stale responses still owed by the cache; can exceed 4 across back-to-back redirects
    logic [3:0]              drop_q, drop_d;

    logic                    req_hs;
    logic                    deq_fire;
    logic                    resp_drop;
    logic                    resp_load;
    logic                    resp_hit;
    logic [ADDR_WIDTH-1:0]   redir_line;

    // Redirect target rounded down to its cache line
    assign redir_line = {redirect_pc[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    // Handshake qualifiers and output strobes; redirect suppresses load and dequeue
    always_comb begin
        fetch_req_valid = (state_q == RUN) && (count_q < CNT_MAX) && (inflight_q < INF_MAX);
        fetch_req_addr  = next_line_q;
        req_hs          = fetch_req_valid && fetch_req_ready;
        head_valid      = (state_q == RUN) && ibuf_valid[head_q];
        head_idx        = head_q;
        head_pc         = head_pc_q;
        deq_fire        = deq_ready && head_valid && !redirect_valid;
        resp_drop       = fetch_resp_valid && (drop_q != 4'd0);
        // A response with nothing owed is a protocol error and never loads
        resp_hit        = resp_drop || (fetch_resp_valid && (inflight_q != 3'd0));
        resp_load       = fetch_resp_valid && (drop_q == 4'd0) && (inflight_q != 3'd0)
                          && !redirect_valid;
        ibuf_load       = resp_load ? (4'b0001 << fill_q) : 4'b0000;
        ibuf_invalidate = 4'b0000;
        if (state_q == FLUSH) begin
            ibuf_invalidate = 4'b1111;
        end else if (deq_fire) begin
            ibuf_invalidate = 4'b0001 << head_q;
        end
    end

    // Next-state for FSM, pointers and counters; redirect overrides every other event
    always_comb begin
        state_d     = state_q;
        next_line_d = next_line_q;
        head_pc_d   = head_pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        count_d     = count_q;
        inflight_d  = inflight_q;
        drop_d      = drop_q;
        if (redirect_valid) begin
            state_d     = FLUSH;
            next_line_d = redir_line;
            head_pc_d   = redir_line;
            head_d      = redir_line[OFF_W +: IDX_W];
            tail_d      = redir_line[OFF_W +: IDX_W];
            fill_d      = redir_line[OFF_W +: IDX_W];
            count_d     = 3'd0;
            inflight_d  = 3'd0;
            // Everything still owed, plus a request accepted this cycle, minus one answered now
            drop_d      = drop_q + 4'(inflight_q) + 4'(req_hs) - 4'(resp_hit);
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                FLUSH:   state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
            if (req_hs) begin
                tail_d      = tail_q + 2'd1;
                next_line_d = next_line_q + LINE_INC;
            end
            if (resp_drop) begin
                drop_d = drop_q - 4'd1;
            end
            if (resp_load) begin
                fill_d = fill_q + 2'd1;
            end
            if (deq_fire) begin
                head_d    = head_q + 2'd1;
                head_pc_d = head_pc_q + LINE_INC;
            end
            count_d    = count_q + 3'(req_hs) - 3'(deq_fire);
            inflight_d = inflight_q + 3'(req_hs) - 3'(resp_load);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            next_line_q <= '0;
            head_pc_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            next_line_q <= next_line_d;
            head_pc_q   <= head_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_ibuff_ctrl.sv
// Bench for ibuff_ctrl: directed scenarios with a scoreboard of expected request addresses and load strobes.
// Responses are generated one cycle after each request handshake unless held back.
// Includes a behavioural model of the 4-entry buffer valid bits.
module tb_ibuff_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_req_addr;
    logic        fetch_resp_valid;
    logic [3:0]  ibuf_valid;
    logic [3:0]  ibuf_load;
    logic [3:0]  ibuf_invalidate;
    logic        deq_ready;
    logic        head_valid;
    logic [1:0]  head_idx;
    logic [31:0] head_pc;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr_q[$];
    logic [3:0]  exp_load_q[$];
    int          pending   = 0;
    bit          auto_resp = 1'b1;
    bit          hs_seen   = 1'b0;

    always #5 clk = ~clk;

    ibuff_ctrl #(.ADDR_WIDTH(32), .LINE_BYTES(16), .MAX_INFLIGHT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_req_addr   (fetch_req_addr),
        .fetch_resp_valid (fetch_resp_valid),
        .ibuf_valid       (ibuf_valid),
        .ibuf_load        (ibuf_load),
        .ibuf_invalidate  (ibuf_invalidate),
        .deq_ready        (deq_ready),
        .head_valid       (head_valid),
        .head_idx         (head_idx),
        .head_pc          (head_pc)
    );

    // Instruction buffer valid bits: set on load, cleared on invalidate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ibuf_valid <= 4'b0000;
        else     ibuf_valid <= (ibuf_valid & ~ibuf_invalidate) | ibuf_load;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_valid"}, 32'(fetch_req_valid), 32'd0);
        check_val({tag, "_req_addr"},  fetch_req_addr,        32'd0);
        check_val({tag, "_load"},      32'(ibuf_load),        32'd0);
        check_val({tag, "_inval"},     32'(ibuf_invalidate),  32'd0);
        check_val({tag, "_head_valid"}, 32'(head_valid),      32'd0);
        check_val({tag, "_head_idx"},  32'(head_idx),         32'd0);
        check_val({tag, "_head_pc"},   head_pc,               32'd0);
    endtask

    // Advance one clock; the cache returns one line per cycle for every accepted request
    task automatic tick();
        @(posedge clk);
        #1;
        if (hs_seen) pending++;
        fetch_resp_valid = 1'b0;
        if (auto_resp && pending > 0) begin
            fetch_resp_valid = 1'b1;
            pending--;
        end
    endtask

    task automatic push_stream(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(16 * i));
    endtask

    task automatic push_loads(input int first_slot);
        for (int i = 0; i < 4; i++) exp_load_q.push_back(4'b0001 << ((first_slot + i) % 4));
    endtask

    task automatic check_drained(input string tag);
        check_val({tag, "_addr_q_empty"}, 32'(exp_addr_q.size()), 32'd0);
        check_val({tag, "_load_q_empty"}, 32'(exp_load_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: pops expectations on each request handshake and each response
    always @(negedge clk) begin
        hs_seen = 1'b0;
        if (!rst) begin
            if (fetch_req_valid && fetch_req_ready) begin
                hs_seen = 1'b1;
                if (exp_addr_q.size() == 0) check_val("req_unexpected", 32'(fetch_req_valid), 32'd0);
                else                        check_val("req_addr", fetch_req_addr, exp_addr_q.pop_front());
            end
            if (fetch_resp_valid) begin
                if (exp_load_q.size() == 0) check_val("resp_unexpected", 32'(fetch_resp_valid), 32'd0);
                else                        check_val("load", 32'(ibuf_load), 32'(exp_load_q.pop_front()));
            end else if (ibuf_load != 4'b0000) begin
                check_val("load_without_resp", 32'(ibuf_load), 32'd0);
            end
            if (ibuf_load != 4'b0000) check_val("load_onto_valid", 32'(ibuf_load & ibuf_valid), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'd0;
        fetch_req_ready  = 1'b1;
        fetch_resp_valid = 1'b0;
        deq_ready        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        #1;
        check_val("idle_no_req", 32'(fetch_req_valid), 32'd0);

        // Fill from 0x1000
        push_stream(32'h1000);
        push_loads(0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_val("flush_inval", 32'(ibuf_invalidate), 32'hF);
        check_val("flush_no_req", 32'(fetch_req_valid), 32'd0);
        check_val("flush_no_load", 32'(ibuf_load), 32'd0);
        repeat (6) tick();
        #1;
        check_val("full_no_req", 32'(fetch_req_valid), 32'd0);
        check_val("full_valid", 32'(ibuf_valid), 32'hF);
        check_val("full_head_valid", 32'(head_valid), 32'd1);
        check_val("full_head_idx", 32'(head_idx), 32'd0);
        check_val("full_head_pc", head_pc, 32'h1000);
        check_drained("s1");

        // Single dequeue from full; freed slot is re-requested the following cycle
        exp_addr_q.push_back(32'h1040);
        exp_load_q.push_back(4'b0001);
        deq_ready = 1'b1;
        #1;
        check_val("deq_inval", 32'(ibuf_invalidate), 32'h1);
        check_val("deq_cycle_no_req", 32'(fetch_req_valid), 32'd0);
        tick();
        deq_ready = 1'b0;
        #1;
        check_val("deq_head_idx", 32'(head_idx), 32'd1);
        check_val("deq_head_pc", head_pc, 32'h1010);
        check_val("refill_req_valid", 32'(fetch_req_valid), 32'd1);
        repeat (2) tick();
        #1;
        check_val("refill_valid", 32'(ibuf_valid), 32'hF);
        check_drained("s2");

        // Two requests in flight, then redirect to 0x2010 with no response that cycle
        auto_resp = 1'b0;
        exp_addr_q.push_back(32'h1050);
        exp_addr_q.push_back(32'h1060);
        deq_ready = 1'b1;
        repeat (2) tick();
        deq_ready = 1'b0;
        tick();
        push_stream(32'h2010);
        exp_load_q.push_back(4'b0000);
        exp_load_q.push_back(4'b0000);
        push_loads(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2010;
        #1;
        check_val("s3_redirect_no_req", 32'(fetch_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        tick();
        auto_resp = 1'b1;
        #1;
        check_val("s3_head_valid", 32'(head_valid), 32'd0);
        check_val("s3_head_idx", 32'(head_idx), 32'd1);
        check_val("s3_head_pc", head_pc, 32'h2010);
        repeat (7) tick();
        #1;
        check_val("s3_full_valid", 32'(ibuf_valid), 32'hF);
        check_val("s3_full_head_valid", 32'(head_valid), 32'd1);
        check_drained("s3");

        // Unaligned redirect 0x3008 aligns to 0x3000, first slot 0
        push_stream(32'h3000);
        push_loads(0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3008;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        #1;
        check_val("s4a_head_idx", 32'(head_idx), 32'd0);
        check_val("s4a_head_pc", head_pc, 32'h3000);
        check_drained("s4a");

        // Same redirect, four requests in flight and one response arriving in the redirect cycle
        auto_resp = 1'b0;
        push_stream(32'h3000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3008;
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        push_stream(32'h3000);
        for (int i = 0; i < 4; i++) exp_load_q.push_back(4'b0000);
        push_loads(0);
        redirect_valid   = 1'b1;
        redirect_pc      = 32'h3008;
        fetch_resp_valid = 1'b1;
        pending--;
        tick();
        redirect_valid = 1'b0;
        tick();
        auto_resp = 1'b1;
        repeat (8) tick();
        #1;
        check_val("s4b_full_valid", 32'(ibuf_valid), 32'hF);
        check_drained("s4b");

        // Request held under backpressure for three cycles
        push_stream(32'h1000);
        push_loads(0);
        fetch_req_ready = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h1000;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check_val("hold_valid", 32'(fetch_req_valid), 32'd1);
            check_val("hold_addr", fetch_req_addr, 32'h1000);
            check_val("hold_head_valid", 32'(head_valid), 32'd0);
        end
        tick();
        fetch_req_ready = 1'b1;
        repeat (5) tick();
        #1;
        check_val("s5_full_valid", 32'(ibuf_valid), 32'hF);
        check_drained("s5");

        // Asynchronous reset in the middle of a RUN stream
        exp_addr_q.push_back(32'h1000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        fetch_resp_valid = 1'b0;
        auto_resp        = 1'b0;
        pending          = 0;
        exp_load_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check_val("post_reset_no_req", 32'(fetch_req_valid), 32'd0);
        end
        check_drained("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
